// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: show-ahead FIFO of sequence-tagged retire records with drop accounting
module retire_trace_fifo #(
  parameter int XLEN = 32,
  parameter int DEPTH = 8,
  parameter int CNTW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ret_valid,
  input  logic [XLEN-1:0]          ret_pc,
  input  logic [XLEN-1:0]          ret_instr,
  input  logic                     ret_rd_we,
  input  logic [4:0]               ret_rd,
  input  logic [XLEN-1:0]          ret_rd_data,
  input  logic                     ret_mem_we,
  input  logic [XLEN-1:0]          ret_mem_addr,
  input  logic [XLEN-1:0]          ret_mem_data,
  input  logic                     flush,
  output logic                     chk_valid,
  input  logic                     chk_ready,
  output logic [31:0]              chk_seq,
  output logic [XLEN-1:0]          chk_pc,
  output logic [XLEN-1:0]          chk_instr,
  output logic                     chk_rd_we,
  output logic [4:0]               chk_rd,
  output logic [XLEN-1:0]          chk_rd_data,
  output logic                     chk_mem_we,
  output logic [XLEN-1:0]          chk_mem_addr,
  output logic [XLEN-1:0]          chk_mem_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [CNTW-1:0]          retired_cnt,
  output logic [CNTW-1:0]          dropped_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]     seq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } rec_t;
  rec_t mem [DEPTH];
  rec_t head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] seq;
  logic pop, push, drop;
  assign chk_valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop = chk_valid && chk_ready;
  assign push = ret_valid && (!full || pop);
  assign drop = ret_valid && full && !pop;
  assign head = mem[rd_ptr];
  assign chk_seq = head.seq;
  assign chk_pc = head.pc;
  assign chk_instr = head.instr;
  assign chk_rd_we = head.rd_we;
  assign chk_rd = head.rd;
  assign chk_rd_data = head.rd_data;
  assign chk_mem_we = head.mem_we;
  assign chk_mem_addr = head.mem_addr;
  assign chk_mem_data = head.mem_data;
  always_ff @(posedge clk) begin
    if (push && !rst && !flush)
      mem[wr_ptr] <= {seq, ret_pc, ret_instr, ret_rd_we, ret_rd, ret_rd_data,
                      ret_mem_we, ret_mem_addr, ret_mem_data};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      seq <= '0;
      overflow <= 1'b0;
      retired_cnt <= '0;
      dropped_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq <= seq + 32'd1;
        retired_cnt <= retired_cnt + CNTW'(retired_cnt != '1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (drop) begin
        dropped_cnt <= dropped_cnt + CNTW'(dropped_cnt != '1);
        overflow <= 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_retire_trace_fifo.sv
// tb_retire_trace_fifo: vector table, directed corners and random traffic against a queue model
module tb_retire_trace_fifo;
  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  localparam int CNTW = 16;
  logic clk = 1'b0;
  logic rst, ret_valid, ret_rd_we, ret_mem_we, flush, chk_ready;
  logic [XLEN-1:0] ret_pc, ret_instr, ret_rd_data, ret_mem_addr, ret_mem_data;
  logic [4:0] ret_rd;
  logic chk_valid, chk_rd_we, chk_mem_we, full, overflow;
  logic [31:0] chk_seq;
  logic [XLEN-1:0] chk_pc, chk_instr, chk_rd_data, chk_mem_addr, chk_mem_data;
  logic [4:0] chk_rd;
  logic [$clog2(DEPTH):0] count;
  logic [CNTW-1:0] retired_cnt, dropped_cnt;
  always #5 clk = ~clk;
  retire_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_rd_we(ret_rd_we), .ret_rd(ret_rd), .ret_rd_data(ret_rd_data),
    .ret_mem_we(ret_mem_we), .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data),
    .flush(flush), .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_seq(chk_seq),
    .chk_pc(chk_pc), .chk_instr(chk_instr), .chk_rd_we(chk_rd_we), .chk_rd(chk_rd),
    .chk_rd_data(chk_rd_data), .chk_mem_we(chk_mem_we), .chk_mem_addr(chk_mem_addr),
    .chk_mem_data(chk_mem_data), .count(count), .full(full), .overflow(overflow),
    .retired_cnt(retired_cnt), .dropped_cnt(dropped_cnt)
  );
  typedef struct {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } rec_t;
  typedef struct {
    bit v;
    logic [31:0] pc;
    bit rdy;
    bit ev;
    int ecnt;
    bit efull;
    bit eovf;
    logic [31:0] eseq;
    logic [31:0] epc;
  } vec_t;
  int total = 0;
  int bad = 0;
  rec_t q[$];
  logic [31:0] mseq;
  int mret, mdrop;
  bit movf;
  vec_t vt[13];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit v, input logic [31:0] pc, input bit rdy, input bit fl, input bit rs);
    rec_t r;
    bit pop, acc, stall;
    logic [31:0] pseq, ppc;
    ret_valid = v;
    ret_pc = pc;
    ret_instr = $urandom;
    ret_rd_we = 1'($urandom);
    ret_rd = 5'($urandom);
    ret_rd_data = $urandom;
    ret_mem_we = 1'($urandom);
    ret_mem_addr = $urandom;
    ret_mem_data = $urandom;
    chk_ready = rdy;
    flush = fl;
    rst = rs;
    r = '{mseq, pc, ret_instr, ret_rd_we, ret_rd, ret_rd_data, ret_mem_we, ret_mem_addr, ret_mem_data};
    stall = (chk_valid === 1'b1) && !rdy && !fl && !rs;
    pseq = chk_seq;
    ppc = chk_pc;
    pop = q.size() != 0 && rdy;
    acc = 0;
    if (rs) begin
      q.delete();
      mseq = 0;
      mret = 0;
      mdrop = 0;
      movf = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (v && (q.size() < DEPTH || pop)) acc = 1;
      else if (v) begin
        if (mdrop < 65535) mdrop++;
        movf = 1;
      end
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(r);
        mseq++;
        if (mret < 65535) mret++;
      end
    end
    @(posedge clk);
    #1;
    chk("chk_valid", 64'(chk_valid), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("retired_cnt", 64'(retired_cnt), 64'(mret));
    chk("dropped_cnt", 64'(dropped_cnt), 64'(mdrop));
    if (q.size() != 0) begin
      chk("chk_seq", 64'(chk_seq), 64'(q[0].seq));
      chk("chk_pc", 64'(chk_pc), 64'(q[0].pc));
      chk("chk_instr", 64'(chk_instr), 64'(q[0].instr));
      chk("chk_rd_we", 64'(chk_rd_we), 64'(q[0].rd_we));
      chk("chk_rd", 64'(chk_rd), 64'(q[0].rd));
      chk("chk_rd_data", 64'(chk_rd_data), 64'(q[0].rd_data));
      chk("chk_mem_we", 64'(chk_mem_we), 64'(q[0].mem_we));
      chk("chk_mem_addr", 64'(chk_mem_addr), 64'(q[0].mem_addr));
      chk("chk_mem_data", 64'(chk_mem_data), 64'(q[0].mem_data));
    end
    if (stall) begin
      chk("stall_seq", 64'(chk_seq), 64'(pseq));
      chk("stall_pc", 64'(chk_pc), 64'(ppc));
    end
  endtask
  initial begin
    logic [31:0] prev;
    vt[0] = '{1, 32'h100, 0, 1, 1, 0, 0, 0, 32'h100};
    vt[1] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) vt[2+i] = '{1, 32'h200 + i, 0, 1, i + 1, i == 7, 0, 1, 32'h200};
    vt[10] = '{1, 32'h999, 0, 1, 8, 1, 1, 1, 32'h200};
    vt[11] = '{1, 32'h300, 1, 1, 8, 1, 1, 2, 32'h201};
    vt[12] = '{0, 0, 1, 1, 7, 0, 1, 3, 32'h202};
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_valid", 64'(chk_valid), 64'(0));
    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].v, vt[i].pc, vt[i].rdy, 0, 0);
      chk($sformatf("vec%0d_valid", i), 64'(chk_valid), 64'(vt[i].ev));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].ecnt));
      chk($sformatf("vec%0d_full", i), 64'(full), 64'(vt[i].efull));
      chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vt[i].eovf));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_seq", i), 64'(chk_seq), 64'(vt[i].eseq));
        chk($sformatf("vec%0d_pc", i), 64'(chk_pc), 64'(vt[i].epc));
      end
    end
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 32'h400 + i, 0, 0, 0);
    cyc(1, 32'hdead, 0, 0, 0);
    chk("burst_drop", 64'(dropped_cnt), 64'(1));
    cyc(1, 32'h500, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_seq", 64'(chk_seq), 64'(i));
      chk("drain_pc", 64'(chk_pc), 64'(i < 8 ? 32'h400 + i : 32'h500));
      cyc(0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 32'h600 + i, 0, 0, 0);
    prev = chk_seq;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 32'h700 + i, 1, 0, 0);
      chk("steady_seq_step", 64'(chk_seq), 64'(prev + 1));
      chk("steady_no_ovf", 64'(overflow), 64'(0));
      prev = chk_seq;
    end
    for (int i = 0; i < 40; i++) cyc(1, 32'h800 + i, i[0], 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 32'h900 + i, 0, 0, 0);
    cyc(1, 32'h9ff, 1, 1, 0);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_retired", 64'(retired_cnt), 64'(5));
    cyc(1, 32'ha00, 0, 0, 0);
    chk("flush_next_seq", 64'(chk_seq), 64'(5));
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 32'hb00 + i, 0, 0, 0);
    cyc(1, 32'hbff, 1, 0, 1);
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_retired", 64'(retired_cnt), 64'(0));
    cyc(1, 32'hc00, 0, 0, 0);
    chk("rst_first_seq", 64'(chk_seq), 64'(0));
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), $urandom_range(0, 24) == 0,
          $urandom_range(0, 99) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Sits between the CPU DUT's writeback/retire stage and the testbench checker that drives the C reference model.
- Captures one retired-instruction record per cycle: PC, instruction word, register write, and memory store.
- Buffers records in order in a circular FIFO, tags each with a sequence number, and presents them to the checker over a valid/ready handshake.
- Keeps the checker decoupled from DUT retire timing; any lost record is flagged.

Parameters:
- XLEN, 32, width of PC, instruction, data and address fields
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
- CNTW, 16, width of the saturating retired and dropped counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ret_valid  in  1  DUT retired an instruction this cycle
- ret_pc  in  XLEN  PC of retired instruction
- ret_instr  in  XLEN  instruction word
- ret_rd_we  in  1  register write performed
- ret_rd  in  5  destination register index
- ret_rd_data  in  XLEN  value written to rd
- ret_mem_we  in  1  store (stl/sth) performed
- ret_mem_addr  in  XLEN  store address
- ret_mem_data  in  XLEN  store data
- flush  in  1  discard all buffered records
- chk_valid  out  1  head record available
- chk_ready  in  1  checker consumes head record
- chk_seq  out  32  sequence number of head record
- chk_pc, chk_instr, chk_rd_we, chk_rd, chk_rd_data, chk_mem_we, chk_mem_addr, chk_mem_data  out  as ret_*  head record fields
- count  out  $clog2(DEPTH)+1  occupancy
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a record was dropped
- retired_cnt  out  CNTW  records accepted, saturating
- dropped_cnt  out  CNTW  records dropped, saturating

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr=rd_ptr=0, count=0, seq counter=0, overflow=0, retired_cnt=dropped_cnt=0.
  - Outputs: chk_valid=0, full=0; chk_* data fields are don't-care while chk_valid=0.
  - rst takes priority over everything. Reset mid-operation discards all entries with no drain.
- Storage:
  - DEPTH-entry array plus pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - count is tracked separately, so full and empty are unambiguous.
- Show-ahead output:
  - chk_valid = (count != 0).
  - chk_* fields are driven from the entry at rd_ptr.
  - Pop occurs when chk_valid && chk_ready.
  - chk_* must hold stable while chk_valid=1 and chk_ready=0.
- Push:
  - Accepted when ret_valid && (count < DEPTH || pop this cycle).
  - The entry is written at wr_ptr; wr_ptr++.
  - The entry is tagged with the current seq value; seq++ with 32-bit wrap.
  - retired_cnt++, saturating at all-ones.
- Write-to-read latency:
  - A record pushed at edge N is visible on chk_* after edge N.
  - There is no same-cycle bypass. With the FIFO empty, chk_valid rises one cycle after ret_valid.
- Simultaneous push and pop:
  - Allowed at any occupancy including full; count is unchanged.
  - When full, the pop frees the slot the push reuses.
- Overflow:
  - Occurs on ret_valid && full && !pop.
  - The record is discarded; seq does NOT increment; dropped_cnt++ (saturating); overflow is set.
  - overflow is cleared only by rst.
- Flush (flush=1, rst=0):
  - Pointers and count go to 0; chk_valid=0 next cycle.
  - A ret_valid in the same cycle is discarded and counted in neither counter.
  - seq, overflow and both counters are retained.
  - A pop in the same cycle is ignored.
- Record fields are captured verbatim. The block performs no decode, and a nop retires as a normal record.

Test Plan:
- Reset then a single push with ret_pc=0x100 and ret_instr=0x12345678. Required: chk_valid=0 in the push cycle and 1 the next cycle; chk_seq=0, chk_pc=0x100; after pop, count=0 and retired_cnt=1.
- Burst of 8 pushes with chk_ready=0 (DEPTH=8). Required: full=1 and count=8. A 9th push gives overflow=1, dropped_cnt=1, and seq of the next accepted record is 8. Draining yields seq 0..7 with matching PCs.
- Full FIFO with ret_valid and chk_ready both high for 20 cycles. Required: count stays 8, overflow does not set, pops see seq strictly increasing by 1, pointer wrap verified.
- Backpressure: chk_ready toggles every other cycle during continuous retire. Required: chk_* stays stable while stalled and no record is lost or duplicated, checked against a scoreboard.
- Flush with 5 entries and ret_valid=1 in the same cycle. Required: count=0 next cycle, retired_cnt unchanged, the next accepted record has seq=5.
- rst asserted mid-burst with 3 entries. Required: all counters, overflow and seq return to 0; the first record after reset has chk_seq=0.
